// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer with PC and IR ownership.
// Optional feature: define BRANCH_EN to add j (0x06) and beq (0x07).
module cpu_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IMEM_READY,
  input  logic        ZERO,
  output logic        IMEM_READ,
  output logic [31:0] PC,
  output logic        REG_WRITE_EN,
  output logic [2:0]  ALUOP,
  output logic        IS_ADD,
  output logic        IS_IMMEDIATE,
  output logic [2:0]  DEST,
  output logic [2:0]  SRC1,
  output logic [2:0]  SRC2,
  output logic [7:0]  IMMEDIATE,
  output logic        ILLEGAL,
  output logic        BUSY
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 3;
  localparam int unsigned IW   = 8;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
`ifdef BRANCH_EN
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
`endif

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            imem_read_q, imem_read_d;
  logic            reg_write_q, reg_write_d;
  logic            wr_q, wr_d;
  logic [RW-1:0]   aluop_q, aluop_d;
  logic            is_add_q, is_add_d;
  logic            is_imm_q, is_imm_d;
  logic [RW-1:0]   dest_q, dest_d;
  logic [RW-1:0]   src1_q, src1_d;
  logic [RW-1:0]   src2_q, src2_d;
  logic [IW-1:0]   imm_q, imm_d;
  logic            illegal_q, illegal_d;
  logic            busy_q, busy_d;

  logic            dec_legal;
  logic [RW-1:0]   dec_aluop;
  logic            dec_is_add;
  logic            dec_is_imm;
  logic            dec_wr;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_next;

  // Opcode decode of the held instruction register.
  always_comb begin
    dec_legal  = 1'b1;
    dec_aluop  = 3'b000;
    dec_is_add = 1'b1;
    dec_is_imm = 1'b0;
    dec_wr     = 1'b1;
    unique case (ir_q[31:24])
      OP_LOADI: dec_is_imm = 1'b1;
      OP_MOV:   dec_aluop  = 3'b000;
      OP_ADD:   dec_aluop  = 3'b001;
      OP_SUB: begin
        dec_aluop  = 3'b001;
        dec_is_add = 1'b0;
      end
      OP_AND:   dec_aluop  = 3'b010;
      OP_OR:    dec_aluop  = 3'b011;
`ifdef BRANCH_EN
      OP_J:     dec_wr     = 1'b0;
      OP_BEQ: begin
        dec_aluop  = 3'b001;
        dec_is_add = 1'b0;
        dec_wr     = 1'b0;
      end
`endif
      default: begin
        dec_legal  = 1'b0;
        dec_is_add = 1'b0;
        dec_wr     = 1'b0;
      end
    endcase
  end

  assign pc_seq = pc_q + PC_STEP;

`ifdef BRANCH_EN
  logic [XLEN-1:0] br_off;
  logic            br_take;
  logic            unused_ir_bits;

  // Word-aligned signed offset relative to the sequential PC.
  assign br_off         = {{(XLEN-10){ir_q[23]}}, ir_q[23:16], 2'b00};
  assign br_take        = (ir_q[31:24] == OP_J) || ((ir_q[31:24] == OP_BEQ) && ZERO);
  assign pc_next        = br_take ? (pc_seq + br_off) : pc_seq;
  assign unused_ir_bits = ^ir_q[15:11];
`else
  logic unused_ir_bits;

  assign pc_next        = pc_seq;
  assign unused_ir_bits = ^{ir_q[23:19], ir_q[15:11], ZERO};
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= FETCH;
      ir_q        <= '0;
      pc_q        <= RESET_PC;
      imem_read_q <= 1'b0;
      reg_write_q <= 1'b0;
      wr_q        <= 1'b0;
      aluop_q     <= '0;
      is_add_q    <= 1'b0;
      is_imm_q    <= 1'b0;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      imem_read_q <= imem_read_d;
      reg_write_q <= reg_write_d;
      wr_q        <= wr_d;
      aluop_q     <= aluop_d;
      is_add_q    <= is_add_d;
      is_imm_q    <= is_imm_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; capture is gated by the registered fetch request so the first
  // edge after reset release never captures.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    reg_write_d = 1'b0;
    wr_d        = wr_q;
    aluop_d     = aluop_q;
    is_add_d    = is_add_q;
    is_imm_d    = is_imm_q;
    dest_d      = dest_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    imm_d       = imm_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      FETCH: begin
        if (imem_read_q && IMEM_READY) begin
          ir_d    = INSTRUCTION;
          state_d = DECODE;
        end
      end
      DECODE: begin
        dest_d   = ir_q[18:16];
        src1_d   = ir_q[10:8];
        src2_d   = ir_q[2:0];
        imm_d    = ir_q[7:0];
        aluop_d  = dec_aluop;
        is_add_d = dec_is_add;
        is_imm_d = dec_is_imm;
        wr_d     = dec_wr;
        if (dec_legal) begin
          state_d = EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      EXECUTE: begin
        reg_write_d = wr_q;
        state_d     = WRITEBACK;
      end
      WRITEBACK: begin
        pc_d    = pc_next;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    imem_read_d = (state_d == FETCH);
    busy_d      = (state_d == DECODE) || (state_d == EXECUTE) || (state_d == WRITEBACK);
  end

  assign IMEM_READ    = imem_read_q;
  assign PC           = pc_q;
  assign REG_WRITE_EN = reg_write_q;
  assign ALUOP        = aluop_q;
  assign IS_ADD       = is_add_q;
  assign IS_IMMEDIATE = is_imm_q;
  assign DEST         = dest_q;
  assign SRC1         = src1_q;
  assign SRC2         = src2_q;
  assign IMMEDIATE    = imm_q;
  assign ILLEGAL      = illegal_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus queues per-instruction expectations,
// a negedge monitor checks each instruction as it passes DECODE/EXECUTE/WRITEBACK.
`timescale 1ns/1ps
module tb_cpu_control_fsm;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        IMEM_READY;
  logic        ZERO;
  logic        IMEM_READ;
  logic [31:0] PC;
  logic        REG_WRITE_EN;
  logic [2:0]  ALUOP;
  logic        IS_ADD;
  logic        IS_IMMEDIATE;
  logic [2:0]  DEST;
  logic [2:0]  SRC1;
  logic [2:0]  SRC2;
  logic [7:0]  IMMEDIATE;
  logic        ILLEGAL;
  logic        BUSY;

  typedef struct {
    logic [2:0]  dest;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [7:0]  imm;
    logic [2:0]  aluop;
    logic        is_add;
    logic        is_imm;
    logic        wr;
    logic        illegal;
    logic        chk_fields;
    logic [31:0] next_pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cpu_control_fsm dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .INSTRUCTION  (INSTRUCTION),
    .IMEM_READY   (IMEM_READY),
    .ZERO         (ZERO),
    .IMEM_READ    (IMEM_READ),
    .PC           (PC),
    .REG_WRITE_EN (REG_WRITE_EN),
    .ALUOP        (ALUOP),
    .IS_ADD       (IS_ADD),
    .IS_IMMEDIATE (IS_IMMEDIATE),
    .DEST         (DEST),
    .SRC1         (SRC1),
    .SRC2         (SRC2),
    .IMMEDIATE    (IMMEDIATE),
    .ILLEGAL      (ILLEGAL),
    .BUSY         (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] dest, input logic [2:0] src1,
                              input logic [2:0] src2, input logic [7:0] imm,
                              input logic [2:0] aluop, input logic is_add,
                              input logic is_imm, input logic wr, input logic illegal,
                              input logic chkf, input logic [31:0] npc);
    exp_t e;
    e.dest = dest; e.src1 = src1; e.src2 = src2; e.imm = imm;
    e.aluop = aluop; e.is_add = is_add; e.is_imm = is_imm; e.wr = wr;
    e.illegal = illegal; e.chk_fields = chkf; e.next_pc = npc;
    return e;
  endfunction

  task automatic chk_reset(input string name);
    chk({name, "_outs"}, 32'({IMEM_READ, REG_WRITE_EN, ALUOP, IS_ADD, IS_IMMEDIATE,
                              DEST, SRC1, SRC2, IMMEDIATE, ILLEGAL, BUSY}), 32'd0);
    chk({name, "_pc"}, PC, 32'h0000_0000);
  endtask

  // Wait for a fetch request, optionally stall, then hand the instruction over.
  task automatic issue(input logic [31:0] instr, input int stall, input logic [31:0] cur_pc,
                       input bit wait_done, input exp_t e, output int cycles);
    int n;
    cycles = 0;
    INSTRUCTION = instr;
    IMEM_READY = 1'b0;
    n = 0;
    while (!IMEM_READ && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    chk("fetch_wait", 32'(IMEM_READ), 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_imem_read", 32'(IMEM_READ), 32'd1);
      chk("stall_pc", PC, cur_pc);
      chk("stall_busy", 32'(BUSY), 32'd0);
      @(posedge CLK); #1; cycles++;
    end
    chk("fetch_pc", PC, cur_pc);
    exp_q.push_back(e);
    IMEM_READY = 1'b1;
    @(posedge CLK); #1; cycles++;
    IMEM_READY = 1'b0;
    if (wait_done) begin
      n = 0;
      while (!IMEM_READ && n < 20) begin
        @(posedge CLK); #1; cycles++; n++;
      end
      chk("done_wait", 32'(IMEM_READ), 32'd1);
    end
  endtask

  task automatic release_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  // Illegal opcode: halt with PC frozen, then reset clears everything at once.
  task automatic illegal_seq(input logic [31:0] instr);
    int cyc;
    issue(instr, 0, 32'h0, 1'b0, mk(3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b0, 32'h0), cyc);
    repeat (4) begin @(posedge CLK); #1; end
    chk("halt_illegal", 32'(ILLEGAL), 32'd1);
    chk("halt_pc", PC, 32'h0);
    chk("halt_no_write", 32'(REG_WRITE_EN), 32'd0);
    chk("halt_no_fetch", 32'(IMEM_READ), 32'd0);
    chk("halt_busy", 32'(BUSY), 32'd0);
    #2 RESET = 1'b0;
    #1 chk_reset("halt_reset");
    exp_q.delete();
    release_reset();
  endtask

  // Monitor: step through each busy stretch and compare against the queue head.
  initial begin
    int   cnt;
    exp_t cur;
    cnt = 0;
    cur = mk(3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        cnt = 0;
      end else if (BUSY) begin
        cnt++;
        if (cnt == 1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: BUSY=1 with no instruction issued at PC 0x%0h", PC);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (cnt != 3) chk("write_only_in_wb", 32'(REG_WRITE_EN), 32'd0);
        if (cnt == 2) begin
          chk("exec_illegal", 32'(ILLEGAL), 32'd0);
          if (cur.chk_fields) begin
            chk("dest", 32'(DEST), 32'(cur.dest));
            chk("src1", 32'(SRC1), 32'(cur.src1));
            chk("src2", 32'(SRC2), 32'(cur.src2));
            chk("immediate", 32'(IMMEDIATE), 32'(cur.imm));
            chk("aluop", 32'(ALUOP), 32'(cur.aluop));
            chk("is_add", 32'(IS_ADD), 32'(cur.is_add));
            chk("is_immediate", 32'(IS_IMMEDIATE), 32'(cur.is_imm));
          end
        end
        if (cnt == 3) chk("wb_write_en", 32'(REG_WRITE_EN), 32'(cur.wr));
      end else if (cnt > 0) begin
        if (cur.illegal) begin
          chk("illegal_busy_cycles", 32'(cnt), 32'd1);
          chk("illegal_flag", 32'(ILLEGAL), 32'd1);
          chk("illegal_no_fetch", 32'(IMEM_READ), 32'd0);
        end else begin
          chk("busy_cycles", 32'(cnt), 32'd3);
          chk("refetch", 32'(IMEM_READ), 32'd1);
        end
        chk("post_write_en", 32'(REG_WRITE_EN), 32'd0);
        chk("next_pc", PC, cur.next_pc);
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    RESET = 1'b0;
    IMEM_READY = 1'b0;
    INSTRUCTION = 32'h0;
    ZERO = 1'b0;
    #3 chk_reset("reset_async");
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk_reset("reset_held");

    // READY rising with reset release must not capture on the first edge.
    INSTRUCTION = 32'h0002_0005;
    IMEM_READY = 1'b1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("release_no_capture", 32'(BUSY), 32'd0);
    chk("release_fetch_req", 32'(IMEM_READ), 32'd1);

    // loadi r2,#5
    issue(32'h0002_0005, 0, 32'h0, 1'b1,
          mk(3'd2, 3'd0, 3'd5, 8'h05, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4), cyc);
    chk("loadi_latency", 32'(cyc), 32'd4);
    // sub r3,r1,r2
    issue(32'h0303_0102, 0, 32'h4, 1'b1,
          mk(3'd3, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8), cyc);
    chk("sub_latency", 32'(cyc), 32'd4);
    // and r1,r2,r3 with three stall cycles
    issue(32'h0401_0203, 3, 32'h8, 1'b1,
          mk(3'd1, 3'd2, 3'd3, 8'h03, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hC), cyc);
    chk("stall_latency", 32'(cyc), 32'd7);
    // or r4,r6,r7
    issue(32'h0504_0607, 0, 32'hC, 1'b1,
          mk(3'd4, 3'd6, 3'd7, 8'h07, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10), cyc);
    // mov r5,r3
    issue(32'h0105_0300, 0, 32'h10, 1'b1,
          mk(3'd5, 3'd3, 3'd0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h14), cyc);

    // add r6,r1,r2 abandoned by reset in EXECUTE
    issue(32'h0206_0102, 0, 32'h14, 1'b0,
          mk(3'd6, 3'd1, 3'd2, 8'h02, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h18), cyc);
    @(posedge CLK);
    #7 RESET = 1'b0;
    #1 chk_reset("abort_async");
    exp_q.delete();
    @(posedge CLK); #1;
    chk("abort_no_write", 32'(REG_WRITE_EN), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    illegal_seq(32'h0900_0000);

`ifdef BRANCH_EN
    // j -3 from 0 lands at 0xFFFF_FFF8; j +1 from there wraps to 0.
    issue(32'h06FD_0000, 0, 32'h0, 1'b1,
          mk(3'd0, 3'd0, 3'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8), cyc);
    issue(32'h0601_0000, 0, 32'hFFFF_FFF8, 1'b1,
          mk(3'd0, 3'd0, 3'd0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0), cyc);
    issue(32'h0001_0001, 0, 32'h0, 1'b1,
          mk(3'd1, 3'd0, 3'd1, 8'h01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4), cyc);
    issue(32'h0001_0001, 0, 32'h4, 1'b1,
          mk(3'd1, 3'd0, 3'd1, 8'h01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8), cyc);
    ZERO = 1'b1;
    issue(32'h07FE_0102, 0, 32'h8, 1'b1,
          mk(3'd6, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4), cyc);
    issue(32'h0001_0001, 0, 32'h4, 1'b1,
          mk(3'd1, 3'd0, 3'd1, 8'h01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8), cyc);
    ZERO = 1'b0;
    issue(32'h07FE_0102, 0, 32'h8, 1'b1,
          mk(3'd6, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC), cyc);
`else
    illegal_seq(32'h0601_0000);
    illegal_seq(32'h07FE_0102);
`endif

    repeat (4) begin @(posedge CLK); #1; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
